func_request_responder: RTL and testbench
=========================================

Name: func_request_responder

Overview:
- Responder side of the two-station function-request scheme. Stations IE01 and IE02 each present a 3-bit function code and a 2-bit profile, and raise a request with a board push-button.
- The block captures each request, arbitrates by profile, executes the granted function for a fixed busy window, then acknowledges the requester(s).
- Sits between the station switch/button inputs and the status LEDs; it is the first clocked block in the design.

Parameters:
DEB_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted
BUSY_CYCLES, 50000000, length of the execution window in clock cycles (must be >= 1)
CNT_W, 26, counter width; must hold max(DEB_CYCLES, BUSY_CYCLES)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_ie01_n  input  1  raw IE01 request button, active-low (pressed = 0)
fun_ie01  input  3  IE01 function code; 000 = no function
prof_ie01  input  2  IE01 profile; larger value = higher priority
btn_ie02_n  input  1  raw IE02 request button, active-low
fun_ie02  input  3  IE02 function code
prof_ie02  input  2  IE02 profile
busy  output  1  high during the execution window
owner  output  2  00 none, 01 IE01, 10 IE02, 11 both (shared execution)
fun_exec  output  3  function code being executed; 000 when idle
ack_ie01  output  1  one-cycle pulse when the IE01 request completes
ack_ie02  output  1  one-cycle pulse when the IE02 request completes
pend_ie01  output  1  IE01 request captured, not yet granted
pend_ie02  output  1  IE02 request captured, not yet granted

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, counters 0, pending and captured fields cleared, round-robin pointer set to IE01. Released synchronously through the normal clock path.
- Per button: 2-FF synchronizer, then debounce counter. The accepted level changes only after DEB_CYCLES consecutive equal synchronized samples.
- An accepted 1->0 transition generates a one-cycle press pulse. Holding the button produces no repeat pulse.
- Capture, on a press pulse: if the station's fun != 000 and the station is not the current owner, set pend_ieXX at the next edge and latch fun/prof as sampled in the pulse cycle. Otherwise ignore the press.
  - A press while already pending overwrites the latched fun/prof.
- FSM states:
  - IDLE -> GRANT when any pend is high.
  - GRANT (1 cycle): select the winner.
    - Only one pending: that station wins.
    - Both pending: higher latched prof wins.
    - Equal prof: the station the round-robin pointer indicates wins; the pointer then flips to the other station.
    - Both pending with identical latched fun: owner=11, both pends cleared (shared execution).
    - Otherwise only the winner's pend is cleared; the loser stays pending.
    - Load the counter with BUSY_CYCLES-1 and latch fun_exec.
  - EXEC: busy=1; decrement the counter each cycle. At counter 0 go to DONE. busy is high for exactly BUSY_CYCLES cycles.
  - DONE (1 cycle): busy=0; pulse ack for the owner (both acks if owner=11); then owner=00, fun_exec=000 -> IDLE.
- Latency: press pulse in cycle t -> pend high at t+1 -> GRANT at t+2 -> busy high from t+3 through t+2+BUSY_CYCLES -> ack at t+3+BUSY_CYCLES.
- Simultaneous events:
  - A press by the non-owner during EXEC/DONE sets its pend normally; it is served next.
  - A press in the same cycle as GRANT is captured but not considered until the next IDLE.
- Changing fun/prof switches after capture has no effect on a pending or executing request.
- Reset asserted mid-EXEC aborts immediately; no ack is ever issued for the aborted request.

Test Plan:
(DEB_CYCLES=4, BUSY_CYCLES=8 for all scenarios)
- Single request: fun_ie01=101, prof=01, btn_ie01_n low for 10 cycles -> pend_ie01 pulse; busy high exactly 8 cycles with owner=01, fun_exec=101; single ack_ie01; then all outputs 0.
- Priority: both buttons pressed in the same cycle, prof_ie01=01, prof_ie02=11, fun 010/011 -> IE02 executes first; pend_ie01 stays high; IE01 executes immediately after IE02's DONE; one ack each in that order.
- Tie and shared function:
  - Equal prof, different fun, two rounds -> winners alternate IE01 then IE02.
  - Equal fun=110 -> owner=11, one 8-cycle window, ack_ie01 and ack_ie02 in the same cycle.
- Debounce and filtering:
  - Button glitch of 3 cycles low -> no pend.
  - Press with fun=000 -> no pend.
  - Owner presses again during EXEC -> ignored, no second execution.
- Reset mid-op: assert rst_n=0 at the 4th busy cycle -> busy, owner, fun_exec, pends drop to 0 asynchronously; after release no ack appears and the FSM is IDLE.

Source files
------------

// File: rtl/func_request_responder.sv
// Responder for the two-station function-request scheme: debounces the
// IE01/IE02 request buttons, captures function/profile on each press,
// arbitrates by profile (round-robin on ties), runs a fixed busy window
// and acknowledges the requester(s).
module func_request_responder #(
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned BUSY_CYCLES = 50000000,
   parameter int unsigned CNT_W       = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_ie01_n,
   input  logic [2:0] fun_ie01,
   input  logic [1:0] prof_ie01,
   input  logic       btn_ie02_n,
   input  logic [2:0] fun_ie02,
   input  logic [1:0] prof_ie02,
   output logic       busy,
   output logic [1:0] owner,
   output logic [2:0] fun_exec,
   output logic       ack_ie01,
   output logic       ack_ie02,
   output logic       pend_ie01,
   output logic       pend_ie02
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;

   state_t           state;
   logic [1:0]       raw;
   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       acc;
   logic [1:0]       press;
   logic [CNT_W-1:0] deb_cnt [2];
   logic [CNT_W-1:0] busy_cnt;
   logic [2:0]       lat_fun1;
   logic [2:0]       lat_fun2;
   logic [1:0]       lat_prof1;
   logic [1:0]       lat_prof2;
   logic             rr;
   logic [1:0]       win;
   logic             flip;
   logic [1:0]       cap;

   assign raw = {btn_ie02_n, btn_ie01_n};

   // Synchronize both buttons and accept a new level only after it has been
   // seen for DEB_CYCLES consecutive samples; flag accepted presses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '1;
         sync_b <= '1;
         acc    <= '1;
         press  <= '0;
         for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         for (int unsigned i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == acc[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               acc[i]     <= sync_b[i];
               deb_cnt[i] <= '0;
               press[i]   <= ~sync_b[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press is captured only for a real function from a station that is
   // not currently being served.
   assign cap = press & {(fun_ie02 != 3'b000), (fun_ie01 != 3'b000)} & ~owner;

   // Winner selection from the latched requests.
   always_comb begin
      win  = '0;
      flip = 1'b0;
      if (pend_ie01 && pend_ie02) begin
         if (lat_fun1 == lat_fun2) begin
            win = 2'b11;
         end else if (lat_prof1 > lat_prof2) begin
            win = 2'b01;
         end else if (lat_prof2 > lat_prof1) begin
            win = 2'b10;
         end else begin
            win  = rr ? 2'b10 : 2'b01;
            flip = 1'b1;
         end
      end else begin
         win = {pend_ie02, pend_ie01};
      end
   end

   // Control FSM with request capture; capture is written last so a press
   // in the GRANT cycle survives the grant clearing its pend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         owner     <= '0;
         fun_exec  <= '0;
         ack_ie01  <= 1'b0;
         ack_ie02  <= 1'b0;
         pend_ie01 <= 1'b0;
         pend_ie02 <= 1'b0;
         lat_fun1  <= '0;
         lat_fun2  <= '0;
         lat_prof1 <= '0;
         lat_prof2 <= '0;
         rr        <= 1'b0;
         busy_cnt  <= '0;
      end else begin
         ack_ie01 <= 1'b0;
         ack_ie02 <= 1'b0;
         case (state)
            IDLE: begin
               if (pend_ie01 || pend_ie02) state <= GRANT;
            end
            GRANT: begin
               if (win == 2'b00) begin
                  state <= IDLE;
               end else begin
                  owner    <= win;
                  fun_exec <= win[0] ? lat_fun1 : lat_fun2;
                  busy_cnt <= BUSY_LAST;
                  busy     <= 1'b1;
                  if (win[0]) pend_ie01 <= 1'b0;
                  if (win[1]) pend_ie02 <= 1'b0;
                  if (flip) rr <= ~rr;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (busy_cnt == '0) begin
                  busy     <= 1'b0;
                  ack_ie01 <= owner[0];
                  ack_ie02 <= owner[1];
                  state    <= DONE;
               end else begin
                  busy_cnt <= busy_cnt - 1'b1;
               end
            end
            DONE: begin
               owner    <= '0;
               fun_exec <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (cap[0]) begin
            pend_ie01 <= 1'b1;
            lat_fun1  <= fun_ie01;
            lat_prof1 <= prof_ie01;
         end
         if (cap[1]) begin
            pend_ie02 <= 1'b1;
            lat_fun2  <= fun_ie02;
            lat_prof2 <= prof_ie02;
         end
      end
   end

endmodule

// File: tb/tb_func_request_responder.sv
// Self-checking bench for func_request_responder with DEB_CYCLES=4,
// BUSY_CYCLES=8. Expected completions are queued as stimulus is applied
// and compared against completions observed on the ack outputs.
module tb_func_request_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_ie01_n, btn_ie02_n;
   logic [2:0] fun_ie01, fun_ie02;
   logic [1:0] prof_ie01, prof_ie02;
   logic       busy;
   logic [1:0] owner;
   logic [2:0] fun_exec;
   logic       ack_ie01, ack_ie02, pend_ie01, pend_ie02;

   typedef struct packed {
      logic [1:0] acks;
      logic [1:0] own;
      logic [2:0] fun;
      logic [1:0] pend;
      logic [7:0] blen;
      logic [7:0] start;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned first_pend1;
   int unsigned busy_seen;
   logic [1:0]  pend_or;

   func_request_responder #(.DEB_CYCLES(4), .BUSY_CYCLES(8), .CNT_W(26)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_ie01_n(btn_ie01_n), .fun_ie01(fun_ie01), .prof_ie01(prof_ie01),
      .btn_ie02_n(btn_ie02_n), .fun_ie02(fun_ie02), .prof_ie02(prof_ie02),
      .busy(busy), .owner(owner), .fun_exec(fun_exec),
      .ack_ie01(ack_ie01), .ack_ie02(ack_ie02),
      .pend_ie01(pend_ie01), .pend_ie02(pend_ie02)
   );

   always #5 clk = ~clk;

   function automatic ev_t mk_ev(input logic [1:0] acks, input logic [1:0] own,
                                 input logic [2:0] fun, input logic [1:0] pend,
                                 input int unsigned start);
      ev_t e;
      e.acks  = acks;
      e.own   = own;
      e.fun   = fun;
      e.pend  = pend;
      e.blen  = 8'd8;
      e.start = start[7:0];
      return e;
   endfunction

   // Runs ncyc cycles from the current negedge, releasing/re-pressing buttons
   // at the given cycles (0 = never) and recording every completion.
   task automatic collect(input int unsigned ncyc, input int unsigned rel1,
                          input int unsigned rel2, input int unsigned rep_on,
                          input int unsigned rep_off);
      ev_t         cur;
      int unsigned blen = 0;
      cur = '0;
      first_pend1 = 0;
      busy_seen = 0;
      pend_or = '0;
      for (int unsigned cyc = 1; cyc <= ncyc; cyc++) begin
         @(negedge clk);
         if (pend_ie01 && first_pend1 == 0) first_pend1 = cyc;
         pend_or |= {pend_ie02, pend_ie01};
         if (busy) begin
            busy_seen++;
            if (blen == 0) begin
               cur.start = cyc[7:0];
               cur.own   = owner;
               cur.fun   = fun_exec;
            end
            blen++;
         end
         if (ack_ie01 || ack_ie02) begin
            cur.acks = {ack_ie02, ack_ie01};
            cur.pend = {pend_ie02, pend_ie01};
            cur.blen = blen[7:0];
            obs.push_back(cur);
            cur = '0;
            blen = 0;
         end
         if (cyc == rel1) btn_ie01_n = 1'b1;
         if (cyc == rel2) btn_ie02_n = 1'b1;
         if (cyc == rep_on) btn_ie01_n = 1'b0;
         if (cyc == rep_off) btn_ie01_n = 1'b1;
      end
   endtask

   task automatic do_reset();
      btn_ie01_n = 1'b1;
      btn_ie02_n = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      obs.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [10:0] o;
      rst_n = 1'b0;
      btn_ie01_n = 1'b1; btn_ie02_n = 1'b1;
      fun_ie01 = 3'b101; fun_ie02 = 3'b011;
      prof_ie01 = 2'b01; prof_ie02 = 2'b10;
      repeat (3) @(negedge clk);
      o = {busy, owner, fun_exec, ack_ie01, ack_ie02, pend_ie01, pend_ie02};
      n_cmp++;
      if (o !== 11'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", o, 11'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic [10:0] o;
      ev_t e, g;
      do_reset();
      fun_ie01 = 3'b101; prof_ie01 = 2'b01;
      btn_ie01_n = 1'b0;
      exp_q.push_back(mk_ev(2'b01, 2'b01, 3'b101, 2'b00, 9));
      collect(40, 10, 0, 0, 0);
      n_cmp++;
      if (first_pend1 != 7) begin
         n_err++;
         $display("FAIL single_pend_latency: got cycle %0d expected cycle 7", first_pend1);
      end
      n_cmp++;
      if (obs.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL single_count: got %0d events expected %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         g = obs.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL single_event: got %h expected %h", g, e);
         end
      end
      o = {busy, owner, fun_exec, ack_ie01, ack_ie02, pend_ie01, pend_ie02};
      n_cmp++;
      if (o !== 11'd0) begin
         n_err++;
         $display("FAIL single_idle_after: got %b expected %b", o, 11'd0);
      end
   endtask

   task automatic test_priority();
      ev_t e, g;
      do_reset();
      fun_ie01 = 3'b010; prof_ie01 = 2'b01;
      fun_ie02 = 3'b011; prof_ie02 = 2'b11;
      btn_ie01_n = 1'b0; btn_ie02_n = 1'b0;
      exp_q.push_back(mk_ev(2'b10, 2'b10, 3'b011, 2'b01, 9));
      exp_q.push_back(mk_ev(2'b01, 2'b01, 3'b010, 2'b00, 20));
      collect(45, 10, 10, 0, 0);
      n_cmp++;
      if (obs.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL priority_count: got %0d events expected %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         g = obs.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL priority_event: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_tie_round_robin();
      ev_t e, g;
      do_reset();
      fun_ie01 = 3'b001; prof_ie01 = 2'b10;
      fun_ie02 = 3'b010; prof_ie02 = 2'b10;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         btn_ie01_n = 1'b0; btn_ie02_n = 1'b0;
         if (r == 0) begin
            exp_q.push_back(mk_ev(2'b01, 2'b01, 3'b001, 2'b10, 9));
            exp_q.push_back(mk_ev(2'b10, 2'b10, 3'b010, 2'b00, 20));
         end else begin
            exp_q.push_back(mk_ev(2'b10, 2'b10, 3'b010, 2'b01, 9));
            exp_q.push_back(mk_ev(2'b01, 2'b01, 3'b001, 2'b00, 20));
         end
         collect(45, 10, 10, 0, 0);
         n_cmp++;
         if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL tie_count round %0d: got %0d events expected %0d", r, obs.size(), exp_q.size());
         end
         while (obs.size() > 0 && exp_q.size() > 0) begin
            g = obs.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
               n_err++;
               $display("FAIL tie_event round %0d: got %h expected %h", r, g, e);
            end
         end
         obs.delete(); exp_q.delete();
      end
   endtask

   task automatic test_shared();
      ev_t e, g;
      do_reset();
      fun_ie01 = 3'b110; prof_ie01 = 2'b01;
      fun_ie02 = 3'b110; prof_ie02 = 2'b10;
      btn_ie01_n = 1'b0; btn_ie02_n = 1'b0;
      exp_q.push_back(mk_ev(2'b11, 2'b11, 3'b110, 2'b00, 9));
      collect(40, 10, 10, 0, 0);
      n_cmp++;
      if (obs.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL shared_count: got %0d events expected %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         g = obs.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL shared_event: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_filtering();
      // 3-cycle glitch, then a press with no function: neither may pend.
      do_reset();
      fun_ie01 = 3'b101; prof_ie01 = 2'b01;
      btn_ie01_n = 1'b0;
      collect(30, 3, 0, 0, 0);
      n_cmp++;
      if (obs.size() != 0 || pend_or !== 2'b00) begin
         n_err++;
         $display("FAIL glitch_filter: got %0d events pend %b expected 0 events pend 00", obs.size(), pend_or);
      end
      obs.delete();
      fun_ie01 = 3'b000;
      btn_ie01_n = 1'b0;
      collect(30, 10, 0, 0, 0);
      n_cmp++;
      if (obs.size() != 0 || pend_or !== 2'b00) begin
         n_err++;
         $display("FAIL zero_fun: got %0d events pend %b expected 0 events pend 00", obs.size(), pend_or);
      end
      obs.delete();
   endtask

   task automatic test_owner_repress();
      ev_t e, g;
      do_reset();
      fun_ie01 = 3'b101; prof_ie01 = 2'b01;
      btn_ie01_n = 1'b0;
      exp_q.push_back(mk_ev(2'b01, 2'b01, 3'b101, 2'b00, 9));
      collect(50, 6, 0, 10, 20);
      n_cmp++;
      if (obs.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL owner_repress_count: got %0d events expected %0d", obs.size(), exp_q.size());
      end
      while (obs.size() > 0 && exp_q.size() > 0) begin
         g = obs.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (g !== e) begin
            n_err++;
            $display("FAIL owner_repress_event: got %h expected %h", g, e);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [1:0]  s;
      logic [10:0] o;
      do_reset();
      fun_ie01 = 3'b011; prof_ie01 = 2'b01;
      fun_ie02 = 3'b100; prof_ie02 = 2'b01;
      btn_ie01_n = 1'b0;
      for (int unsigned cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 3) btn_ie02_n = 1'b0;
         if (cyc == 10) btn_ie01_n = 1'b1;
      end
      s = {busy, pend_ie02};
      n_cmp++;
      if (s !== 2'b11) begin
         n_err++;
         $display("FAIL midexec_before_reset: got busy,pend_ie02=%b expected 11", s);
      end
      btn_ie02_n = 1'b1;
      rst_n = 1'b0;
      #1;
      o = {busy, owner, fun_exec, ack_ie01, ack_ie02, pend_ie01, pend_ie02};
      n_cmp++;
      if (o !== 11'd0) begin
         n_err++;
         $display("FAIL midexec_async_clear: got %b expected %b", o, 11'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      collect(30, 0, 0, 0, 0);
      n_cmp++;
      if (obs.size() != 0 || busy_seen != 0 || pend_or !== 2'b00) begin
         n_err++;
         $display("FAIL midexec_after_release: got %0d acks, %0d busy cycles, pend %b expected none",
                  obs.size(), busy_seen, pend_or);
      end
      obs.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_tie_round_robin();
      test_shared();
      test_filtering();
      test_owner_repress();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
